fetch_sequencer: RTL and testbench

Sequencer for the instruction-fetch stage. Owns the program counter, issues requests to a variable-latency instruction memory through a req/ready handshake and presents fetched instructions to the IF/ID register with a valid bit. Also applies ID-stage freeze (hazard stall) and EX-stage branch redirects. When a branch arrives while a memory access is still in flight, the sequencer drains that stale access.

---
 rtl/fetch_sequencer_if.sv | 35 +++
 rtl/fetch_sequencer.sv | 160 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
//------------------------------------------------------------------------------
// Module   : fetch_sequencer_if
// Brief    : Control, instruction-memory and IF/ID signal bundle for the
//            fetch sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fetch_sequencer_if;
  logic        freeze;
  logic        br_taken;
  logic [31:0] br_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [15:0] stall_count;

  // Sequencer side
  modport master (
    input  freeze, br_taken, br_addr, mem_ready, mem_rdata,
    output mem_req, mem_addr, if_valid, if_instr, if_pc, stall_count
  );

  // Pipeline / memory side
  modport slave (
    output freeze, br_taken, br_addr, mem_ready, mem_rdata,
    input  mem_req, mem_addr, if_valid, if_instr, if_pc, stall_count
  );
endinterface

`default_nettype wire

// File: rtl/fetch_sequencer.sv
//------------------------------------------------------------------------------
// Module   : fetch_sequencer
// Brief    : Instruction-fetch sequencer. Owns the PC, runs the req/ready
//            handshake to instruction memory, feeds IF/ID with a valid bit,
//            honours ID freeze and EX branch redirects, and drains any
//            access left in flight by a redirect.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic          clk,
  input  wire logic          rst,
  fetch_sequencer_if.master  bus
);

  localparam logic [1:0] c_ST_FETCH = 2'd0;
  localparam logic [1:0] c_ST_HOLD  = 2'd1;
  localparam logic [1:0] c_ST_DRAIN = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_drain_addr;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc;
  logic        r_if_valid;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc;
  logic [15:0] r_stall_count;
  logic        w_mem_req;
  logic [31:0] w_mem_addr;
  logic [31:0] w_pc_plus4;

  // Next sequential address; wraps naturally modulo 2^32.
  assign w_pc_plus4 = r_pc + 32'd4;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a branch always beats freeze.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_FETCH: begin
        if (bus.br_taken) begin
          // An unfinished access must still complete before refetching.
          w_state_nxt = bus.mem_ready ? c_ST_FETCH : c_ST_DRAIN;
        end else if (bus.mem_ready && bus.freeze) begin
          w_state_nxt = c_ST_HOLD;
        end
      end
      c_ST_HOLD: begin
        if (bus.br_taken || !bus.freeze) begin
          w_state_nxt = c_ST_FETCH;
        end
      end
      c_ST_DRAIN: begin
        if (bus.mem_ready) begin
          w_state_nxt = c_ST_FETCH;
        end
      end
      default: w_state_nxt = c_ST_FETCH;
    endcase
  end

  // Memory request outputs; the request is never raised while in reset.
  always_comb begin
    w_mem_req  = 1'b0;
    w_mem_addr = r_pc;
    if (!rst && (r_state != c_ST_HOLD)) begin
      w_mem_req = 1'b1;
    end
    if (r_state == c_ST_DRAIN) begin
      w_mem_addr = r_drain_addr;
    end
  end

  // PC, skid buffer and IF/ID output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_drain_addr <= 32'd0;
      r_skid_instr <= 32'd0;
      r_skid_pc    <= 32'd0;
      r_if_valid   <= 1'b0;
      r_if_instr   <= 32'd0;
      r_if_pc      <= 32'd0;
    end else begin
      case (r_state)
        c_ST_FETCH: begin
          if (bus.br_taken) begin
            r_pc       <= bus.br_addr;
            r_if_valid <= 1'b0;
            if (!bus.mem_ready) begin
              r_drain_addr <= r_pc;
            end
          end else if (bus.mem_ready) begin
            r_pc <= w_pc_plus4;
            if (bus.freeze) begin
              // ID cannot take it yet: park the word until freeze lifts.
              r_skid_instr <= bus.mem_rdata;
              r_skid_pc    <= w_pc_plus4;
            end else begin
              r_if_instr <= bus.mem_rdata;
              r_if_pc    <= w_pc_plus4;
              r_if_valid <= 1'b1;
            end
          end else if (!bus.freeze) begin
            r_if_valid <= 1'b0;
          end
        end
        c_ST_HOLD: begin
          if (bus.br_taken) begin
            r_pc       <= bus.br_addr;
            r_if_valid <= 1'b0;
          end else if (!bus.freeze) begin
            r_if_instr <= r_skid_instr;
            r_if_pc    <= r_skid_pc;
            r_if_valid <= 1'b1;
          end
        end
        c_ST_DRAIN: begin
          r_if_valid <= 1'b0;
          if (bus.br_taken) begin
            r_pc <= bus.br_addr;
          end
        end
        default: r_if_valid <= 1'b0;
      endcase
    end
  end

  // Saturating count of cycles spent waiting on memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= 16'd0;
    end else if (w_mem_req && !bus.mem_ready && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign bus.mem_req     = w_mem_req;
  assign bus.mem_addr    = w_mem_addr;
  assign bus.if_valid    = r_if_valid;
  assign bus.if_instr    = r_if_instr;
  assign bus.if_pc       = r_if_pc;
  assign bus.stall_count = r_stall_count;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_fetch_sequencer
// Brief    : Scoreboard bench for fetch_sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_sequencer;

  localparam logic [31:0] c_K = 32'hA5A5_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  exp_t sb_q[$];

  fetch_sequencer_if bus ();
  fetch_sequencer_if bus_w ();

  fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk (clk),
    .rst (rst),
    .bus (bus_w)
  );

  // Memory models: instruction word is a function of its address.
  assign bus.mem_rdata     = bus.mem_addr ^ c_K;
  assign bus_w.mem_rdata   = bus_w.mem_addr ^ c_K;
  assign bus_w.mem_ready   = 1'b1;
  assign bus_w.freeze      = 1'b0;
  assign bus_w.br_taken    = 1'b0;
  assign bus_w.br_addr     = 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] addr);
    exp_t e;
    e.pc    = addr + 32'd4;
    e.instr = addr ^ c_K;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.freeze   = 1'b0;
    bus.br_taken = 1'b0;
    bus.br_addr  = 32'd0;
    bus.mem_ready = 1'b1;
    sb_q.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic sb_done(input string tag);
    @(negedge clk);
    #1;
    check_eq(tag, 32'(sb_q.size()), 32'd0);
  endtask

  // Scoreboard monitor: each newly presented valid instruction is popped and compared.
  logic        prev_v;
  logic [31:0] prev_pc;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (bus.if_valid && (!prev_v || (bus.if_pc != prev_pc))) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
          e = sb_q.pop_front();
          check_eq("sb_pc", bus.if_pc, e.pc);
          check_eq("sb_instr", bus.if_instr, e.instr);
        end
      end
      prev_v  = bus.if_valid;
      prev_pc = bus.if_pc;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_stall;
    n_checks = 0;
    n_errors = 0;
    prev_v   = 1'b0;
    prev_pc  = 32'd0;

    // Reset state
    rst = 1'b1;
    bus.freeze = 1'b0; bus.br_taken = 1'b0; bus.br_addr = 32'd0; bus.mem_ready = 1'b1;
    tick();
    tick();
    #1;
    check_eq("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check_eq("rst_if_valid", 32'(bus.if_valid), 32'd0);
    check_eq("rst_if_instr", bus.if_instr, 32'd0);
    check_eq("rst_if_pc", bus.if_pc, 32'd0);
    check_eq("rst_stall", 32'(bus.stall_count), 32'd0);
    rst = 1'b0;

    // Zero-wait stream, plus the wrapping instance
    for (int i = 0; i < 8; i++) begin
      #1;
      check_eq("zw_mem_addr", bus.mem_addr, 32'(4 * i));
      if (i >= 1) check_eq("zw_if_valid", 32'(bus.if_valid), 32'd1);
      if (i == 0) check_eq("wrap_addr0", bus_w.mem_addr, 32'hFFFF_FFFC);
      if (i == 1) begin
        check_eq("wrap_addr1", bus_w.mem_addr, 32'd0);
        check_eq("wrap_if_pc", bus_w.if_pc, 32'd0);
      end
      push_exp(32'(4 * i));
      tick();
    end
    #1;
    check_eq("zw_stall", 32'(bus.stall_count), 32'd0);
    sb_done("zw_sb_empty");

    // Two wait states per instruction
    do_reset();
    exp_stall = 0;
    for (int k = 0; k < 9; k++) begin
      bus.mem_ready = ((k % 3) == 2);
      #1;
      check_eq("ws_mem_addr", bus.mem_addr, 32'(4 * (k / 3)));
      check_eq("ws_if_valid", 32'(bus.if_valid), 32'((k >= 3) && ((k % 3) == 0)));
      check_eq("ws_stall", 32'(bus.stall_count), 32'(exp_stall));
      if (bus.mem_ready) push_exp(32'(4 * (k / 3)));
      else exp_stall++;
      tick();
    end
    #1;
    check_eq("ws_if_valid_end", 32'(bus.if_valid), 32'd1);
    sb_done("ws_sb_empty");

    // Freeze on a completed fetch at 0x10
    do_reset();
    for (int i = 0; i < 4; i++) begin
      #1;
      push_exp(32'(4 * i));
      tick();
    end
    bus.freeze = 1'b1;
    #1;
    check_eq("fz_mem_addr", bus.mem_addr, 32'h10);
    push_exp(32'h10);
    tick();
    for (int i = 0; i < 2; i++) begin
      #1;
      check_eq("fz_hold_req", 32'(bus.mem_req), 32'd0);
      check_eq("fz_hold_pc", bus.if_pc, 32'h10);
      check_eq("fz_hold_instr", bus.if_instr, 32'h0C ^ c_K);
      tick();
    end
    bus.freeze = 1'b0;
    #1;
    check_eq("fz_rel_req", 32'(bus.mem_req), 32'd0);
    tick();
    #1;
    check_eq("fz_next_addr", bus.mem_addr, 32'h14);
    check_eq("fz_if_pc", bus.if_pc, 32'h14);
    push_exp(32'h14);
    tick();
    sb_done("fz_sb_empty");

    // Branch with an outstanding access
    do_reset();
    for (int i = 0; i < 16; i++) begin
      #1;
      push_exp(32'(4 * i));
      tick();
    end
    bus.mem_ready = 1'b0; bus.br_taken = 1'b1; bus.br_addr = 32'h200;
    #1;
    check_eq("br_addr_t0", bus.mem_addr, 32'h40);
    tick();
    bus.br_taken = 1'b0;
    #1;
    check_eq("br_drain_addr1", bus.mem_addr, 32'h40);
    check_eq("br_drain_req", 32'(bus.mem_req), 32'd1);
    check_eq("br_drain_valid1", 32'(bus.if_valid), 32'd0);
    tick();
    bus.mem_ready = 1'b1;
    #1;
    check_eq("br_drain_addr2", bus.mem_addr, 32'h40);
    check_eq("br_drain_valid2", 32'(bus.if_valid), 32'd0);
    tick();
    #1;
    check_eq("br_target_addr", bus.mem_addr, 32'h200);
    check_eq("br_target_valid", 32'(bus.if_valid), 32'd0);
    check_eq("br_stall", 32'(bus.stall_count), 32'd2);
    push_exp(32'h200);
    tick();
    #1;
    check_eq("br_valid_after", 32'(bus.if_valid), 32'd1);
    sb_done("br_sb_empty");

    // Branch and freeze together while in HOLD
    do_reset();
    for (int i = 0; i < 2; i++) begin
      #1;
      push_exp(32'(4 * i));
      tick();
    end
    bus.freeze = 1'b1;
    #1;
    tick();
    bus.br_taken = 1'b1; bus.br_addr = 32'h300;
    #1;
    check_eq("hb_hold_req", 32'(bus.mem_req), 32'd0);
    tick();
    bus.br_taken = 1'b0; bus.freeze = 1'b0;
    #1;
    check_eq("hb_if_valid", 32'(bus.if_valid), 32'd0);
    check_eq("hb_mem_addr", bus.mem_addr, 32'h300);
    push_exp(32'h300);
    tick();
    #1;
    check_eq("hb_valid_after", 32'(bus.if_valid), 32'd1);
    sb_done("hb_sb_empty");

    // Reset while draining
    do_reset();
    bus.mem_ready = 1'b0; bus.br_taken = 1'b1; bus.br_addr = 32'h80;
    #1;
    tick();
    bus.br_taken = 1'b0;
    #1;
    check_eq("rd_drain_addr", bus.mem_addr, 32'd0);
    check_eq("rd_stall_pre", 32'(bus.stall_count), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rd_req_in_rst1", 32'(bus.mem_req), 32'd0);
    tick();
    #1;
    check_eq("rd_req_in_rst2", 32'(bus.mem_req), 32'd0);
    tick();
    rst = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    check_eq("rd_req_after", 32'(bus.mem_req), 32'd1);
    check_eq("rd_addr_after", bus.mem_addr, 32'd0);
    check_eq("rd_stall_after", 32'(bus.stall_count), 32'd0);
    push_exp(32'd0);
    tick();
    #1;
    check_eq("rd_valid_after", 32'(bus.if_valid), 32'd1);
    sb_done("rd_sb_empty");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
